dmem_req_unit: RTL and testbench



---
 rtl/dmem_req_unit.sv | 156 +++++++++++++++
 tb/tb_dmem_req_unit.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_req_unit.sv
// dmem_req_unit: blocking, single-outstanding load/store initiator between
// the LSU issue stage and the data-memory port. Aligns each request to a
// word address with byte-lane enables, drives the dcache port and returns a
// tagged response carrying extended load data or a misalignment exception.
module dmem_req_unit #(
    parameter int CPU_ADDR_BITS = 32,
    parameter int CPU_DATA_BITS = 32,
    parameter int TAG_BITS      = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_val,
    output logic                     req_rdy,
    input  logic                     req_is_store,
    input  logic [1:0]               req_size,
    input  logic                     req_unsigned,
    input  logic [CPU_ADDR_BITS-1:0] req_addr,
    input  logic [CPU_DATA_BITS-1:0] req_wdata,
    input  logic [TAG_BITS-1:0]      req_tag,
    input  logic                     flush,
    output logic                     rsp_val,
    input  logic                     rsp_rdy,
    output logic [TAG_BITS-1:0]      rsp_tag,
    output logic [CPU_DATA_BITS-1:0] rsp_data,
    output logic                     rsp_exc,
    output logic                     rsp_is_store,
    output logic [CPU_ADDR_BITS-1:0] dcache_addr,
    output logic                     dcache_re,
    output logic [3:0]               dcache_we,
    output logic [CPU_DATA_BITS-1:0] dcache_din,
    input  logic [CPU_DATA_BITS-1:0] dcache_dout,
    input  logic                     dcache_dout_val,
    input  logic                     dcache_stall
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]               state;
    logic                     lat_store;
    logic [1:0]               lat_size;
    logic                     lat_uns;
    logic [CPU_ADDR_BITS-1:0] lat_addr;
    logic [CPU_DATA_BITS-1:0] lat_wdata;
    logic [TAG_BITS-1:0]      lat_tag;
    logic                     lat_exc;
    logic [CPU_DATA_BITS-1:0] rsp_data_q;

    logic                     accept;
    logic                     misaligned;
    logic                     issue_go;
    logic [1:0]               off;
    logic [3:0]               lane_mask;
    logic [CPU_DATA_BITS-1:0] din_rep;
    logic [CPU_DATA_BITS-1:0] shifted;
    logic [CPU_DATA_BITS-1:0] load_ext;

    assign off      = lat_addr[1:0];
    assign accept   = (state == S_IDLE) && req_val && !flush;
    assign issue_go = (state == S_ISSUE) && !flush && !dcache_stall;

    // Request decode, lane mask, store replication and load extraction
    always_comb begin
        misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                     ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) ||
                     (req_size == 2'b11);
        lane_mask = 4'b1111;
        din_rep   = lat_wdata;
        shifted   = dcache_dout >> {off, 3'b000};
        load_ext  = shifted;
        case (lat_size)
            2'b00: begin
                lane_mask = 4'b0001 << off;
                din_rep   = {4{lat_wdata[7:0]}};
                load_ext  = {{24{~lat_uns & shifted[7]}}, shifted[7:0]};
            end
            2'b01: begin
                lane_mask = 4'b0011 << off;
                din_rep   = {2{lat_wdata[15:0]}};
                load_ext  = {{16{~lat_uns & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                lane_mask = 4'b1111;
                din_rep   = lat_wdata;
                load_ext  = shifted;
            end
        endcase
    end

    // Control state machine; flush takes priority over every other event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (accept) state <= misaligned ? S_RESP : S_ISSUE;
                S_ISSUE: begin
                    if (flush)              state <= S_IDLE;
                    else if (!dcache_stall) state <= lat_store ? S_RESP : S_WAIT;
                end
                S_WAIT: begin
                    if (flush)                state <= S_IDLE;
                    else if (dcache_dout_val) state <= S_RESP;
                end
                default: if (flush || rsp_rdy) state <= S_IDLE;
            endcase
        end
    end

    // Capture request fields on the accepting handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_store <= 1'b0;
            lat_size  <= 2'b00;
            lat_uns   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_tag   <= '0;
            lat_exc   <= 1'b0;
        end else if (accept) begin
            lat_store <= req_is_store;
            lat_size  <= req_size;
            lat_uns   <= req_unsigned;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_tag   <= req_tag;
            lat_exc   <= misaligned;
        end
    end

    // Response data: cleared on accept, loaded with the extended lane in WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_q <= '0;
        end else if (accept) begin
            rsp_data_q <= '0;
        end else if ((state == S_WAIT) && !flush && dcache_dout_val) begin
            rsp_data_q <= load_ext;
        end
    end

    assign req_rdy      = (state == S_IDLE) && !flush;
    assign rsp_val      = (state == S_RESP);
    assign rsp_tag      = lat_tag;
    assign rsp_data     = rsp_data_q;
    assign rsp_exc      = lat_exc;
    assign rsp_is_store = lat_store;

    assign dcache_addr  = {lat_addr[CPU_ADDR_BITS-1:2], 2'b00};
    assign dcache_din   = din_rep;
    assign dcache_re    = issue_go && !lat_store;
    assign dcache_we    = (issue_go && lat_store) ? lane_mask : 4'b0000;

endmodule

// File: tb/tb_dmem_req_unit.sv
// Self-checking bench for dmem_req_unit: a simple dcache emulator on the
// memory side and a byte-array reference model that predicts every response.
module tb_dmem_req_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_val, req_rdy, req_is_store, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_tag;
    logic        flush;
    logic        rsp_val, rsp_rdy, rsp_exc, rsp_is_store;
    logic [4:0]  rsp_tag;
    logic [31:0] rsp_data;
    logic [31:0] dcache_addr, dcache_din, dcache_dout;
    logic        dcache_re, dcache_dout_val, dcache_stall;
    logic [3:0]  dcache_we;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_req_unit #(
        .CPU_ADDR_BITS(32),
        .CPU_DATA_BITS(32),
        .TAG_BITS(5)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_val(req_val), .req_rdy(req_rdy), .req_is_store(req_is_store),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_tag(req_tag), .flush(flush),
        .rsp_val(rsp_val), .rsp_rdy(rsp_rdy), .rsp_tag(rsp_tag),
        .rsp_data(rsp_data), .rsp_exc(rsp_exc), .rsp_is_store(rsp_is_store),
        .dcache_addr(dcache_addr), .dcache_re(dcache_re), .dcache_we(dcache_we),
        .dcache_din(dcache_din), .dcache_dout(dcache_dout),
        .dcache_dout_val(dcache_dout_val), .dcache_stall(dcache_stall)
    );

    // dcache emulator: byte-lane writes at the edge, 1-cycle read latency
    logic [7:0]  emu_mem [0:1023];
    logic        emu_init = 1'b0;
    logic        emu_val  = 1'b0;
    logic [31:0] emu_dout = '0;
    logic        inject_val = 1'b0;
    int          emu_wr_cnt = 0;

    assign dcache_dout_val = emu_val | inject_val;
    assign dcache_dout     = emu_dout;

    always @(posedge clk) begin
        if (!emu_init) begin
            for (int i = 0; i < 1024; i++) emu_mem[i] <= 8'(i * 37 + 11);
            emu_init <= 1'b1;
        end else begin
            for (int i = 0; i < 4; i++)
                if (dcache_we[i]) emu_mem[{dcache_addr[9:2], 2'(i)}] <= dcache_din[8*i +: 8];
            if (dcache_we != 4'b0000) emu_wr_cnt <= emu_wr_cnt + 1;
        end
        emu_val  <= dcache_re;
        emu_dout <= {emu_mem[{dcache_addr[9:2], 2'd3}], emu_mem[{dcache_addr[9:2], 2'd2}],
                     emu_mem[{dcache_addr[9:2], 2'd1}], emu_mem[{dcache_addr[9:2], 2'd0}]};
    end

    // Reference memory, little-endian bytes
    logic [7:0] ref_mem [0:1023];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [31:0] a);
        int n;
        if (sz == 2'd3) return 1'b1;
        n = 1 << sz;
        return (a % n) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                                input logic [31:0] a);
        int n = 1 << sz;
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[(a + i) % 1024]) << (8 * i));
        if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    function automatic logic [3:0] model_mask(input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] m = '0;
        for (int i = 0; i < (1 << sz); i++) m[(a % 4) + i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] model_din(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] d = '0;
        int n = 1 << sz;
        for (int j = 0; j < 4; j++) d[8*j +: 8] = wd[8*(j % n) +: 8];
        return d;
    endfunction

    task automatic drive_req(input logic st, input logic [1:0] sz, input logic uns,
                             input logic [31:0] a, input logic [31:0] wd, input logic [4:0] tg);
        req_val = 1'b1; req_is_store = st; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd; req_tag = tg;
    endtask

    // One full transaction with stall/backpressure, checked against the model
    task automatic run_txn(input logic st, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd, input logic [4:0] tg,
                           input int stall_n, input int bp_n, output logic [31:0] got);
        logic        exc;
        int          exp_lat, lat, re_n, we_n, re_k, we_k, rdy_bad;
        logic [31:0] exp_data, hold_data;
        logic [4:0]  hold_tag;
        exc      = is_misaligned(sz, a);
        exp_lat  = exc ? 1 : (st ? 2 + stall_n : 3 + stall_n);
        exp_data = (exc || st) ? 32'h0 : model_load(sz, uns, a);
        lat = -1; re_n = 0; we_n = 0; re_k = -1; we_k = -1; rdy_bad = 0;
        got = '0;
        @(negedge clk);
        drive_req(st, sz, uns, a, wd, tg);
        #1 chk("req_rdy_idle", {31'b0, req_rdy}, 32'd1);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            req_val = 1'b0;
            dcache_stall = (k <= stall_n);
            #1;
            if (dcache_re) begin
                re_n++; re_k = k;
                chk("rd_addr", dcache_addr, a & ~32'h3);
            end
            if (dcache_we != 4'b0000) begin
                we_n++; we_k = k;
                chk("wr_addr", dcache_addr, a & ~32'h3);
                chk("wr_mask", {28'b0, dcache_we}, {28'b0, model_mask(sz, a)});
                chk("wr_din", dcache_din, model_din(sz, wd));
            end
            if (rsp_val) begin
                lat = k;
                break;
            end
            if (req_rdy) rdy_bad++;
        end
        dcache_stall = 1'b0;
        chk("latency", lat, exp_lat);
        chk("re_cycles", re_n, (!st && !exc) ? 1 : 0);
        chk("we_cycles", we_n, (st && !exc) ? 1 : 0);
        if (re_n == 1) chk("re_cycle_idx", re_k, 1 + stall_n);
        if (we_n == 1) chk("we_cycle_idx", we_k, 1 + stall_n);
        chk("req_rdy_busy", rdy_bad, 0);
        if (lat > 0) begin
            chk("rsp_tag", {27'b0, rsp_tag}, {27'b0, tg});
            chk("rsp_data", rsp_data, exp_data);
            chk("rsp_exc", {31'b0, rsp_exc}, {31'b0, exc});
            chk("rsp_is_store", {31'b0, rsp_is_store}, {31'b0, st});
            got = rsp_data;
            hold_data = rsp_data;
            hold_tag  = rsp_tag;
            for (int b = 0; b < bp_n; b++) begin
                @(negedge clk); #1;
                chk("bp_rsp_val", {31'b0, rsp_val}, 32'd1);
                chk("bp_data", rsp_data, hold_data);
                chk("bp_tag", {27'b0, rsp_tag}, {27'b0, hold_tag});
                chk("bp_req_rdy", {31'b0, req_rdy}, 32'd0);
            end
            rsp_rdy = 1'b1;
            @(negedge clk);
            rsp_rdy = 1'b0;
            #1;
            chk("rsp_done", {31'b0, rsp_val}, 32'd0);
            chk("req_rdy_after", {31'b0, req_rdy}, 32'd1);
        end
        if (st && !exc)
            for (int i = 0; i < (1 << sz); i++) ref_mem[(a + i) % 1024] = wd[8*i +: 8];
    endtask

    task automatic quiet_cycles(input string tag, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
            if (rsp_val || dcache_re || dcache_we != 4'b0000) bad++;
        end
        chk(tag, bad, 0);
    endtask

    task automatic flush_in_issue(input logic [31:0] a, input logic [31:0] wd);
        int n0 = emu_wr_cnt;
        @(negedge clk); drive_req(1'b1, 2'd2, 1'b0, a, wd, 5'd7);
        @(negedge clk); req_val = 1'b0; flush = 1'b1;
        #1 chk("fl_issue_we", {28'b0, dcache_we}, 32'd0);
        @(negedge clk); flush = 1'b0;
        #1 chk("fl_issue_rsp", {31'b0, rsp_val}, 32'd0);
        chk("fl_issue_rdy", {31'b0, req_rdy}, 32'd1);
        quiet_cycles("fl_issue_quiet", 3);
        chk("fl_issue_nowr", emu_wr_cnt, n0);
    endtask

    task automatic flush_in_wait(input logic [31:0] a);
        @(negedge clk); drive_req(1'b0, 2'd2, 1'b0, a, 32'h0, 5'd9);
        @(negedge clk); req_val = 1'b0;
        #1 chk("fl_wait_re", {31'b0, dcache_re}, 32'd1);
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        #1 chk("fl_wait_rdy", {31'b0, req_rdy}, 32'd1);
        quiet_cycles("fl_wait_quiet", 4);
    endtask

    task automatic flush_in_resp(input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk); drive_req(1'b1, 2'd2, 1'b0, a, wd, 5'd3);
        @(negedge clk); req_val = 1'b0;
        @(negedge clk);
        #1 chk("fl_resp_val", {31'b0, rsp_val}, 32'd1);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        #1 chk("fl_resp_drop", {31'b0, rsp_val}, 32'd0);
        for (int i = 0; i < 4; i++) ref_mem[(a + i) % 1024] = wd[8*i +: 8];
    endtask

    task automatic flush_with_req();
        int n0 = emu_wr_cnt;
        @(negedge clk); drive_req(1'b1, 2'd2, 1'b0, 32'h120, 32'h5555AAAA, 5'd1); flush = 1'b1;
        #1 chk("fl_req_rdy", {31'b0, req_rdy}, 32'd0);
        @(negedge clk); req_val = 1'b0; flush = 1'b0;
        #1 chk("fl_req_idle", {31'b0, req_rdy}, 32'd1);
        quiet_cycles("fl_req_quiet", 3);
        chk("fl_req_nowr", emu_wr_cnt, n0);
    endtask

    task automatic reset_in_wait(input logic [31:0] a);
        int n0 = emu_wr_cnt;
        @(negedge clk); drive_req(1'b0, 2'd2, 1'b0, a, 32'h0, 5'd21);
        @(negedge clk); req_val = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        #1 chk("rst_re", {31'b0, dcache_re}, 32'd0);
        chk("rst_we", {28'b0, dcache_we}, 32'd0);
        chk("rst_rsp_val", {31'b0, rsp_val}, 32'd0);
        chk("rst_addr", dcache_addr, 32'd0);
        @(negedge clk); rst_n = 1'b1; inject_val = 1'b1;
        #1 chk("rst_rdy", {31'b0, req_rdy}, 32'd1);
        @(negedge clk); inject_val = 1'b0;
        quiet_cycles("rst_stale_quiet", 4);
        chk("rst_nowr", emu_wr_cnt, n0);
    endtask

    task automatic reset_in_issue(input logic [31:0] a);
        int n0 = emu_wr_cnt;
        @(negedge clk); drive_req(1'b1, 2'd2, 1'b0, a, 32'h0BADF00D, 5'd2);
        @(negedge clk); req_val = 1'b0; dcache_stall = 1'b1;
        @(negedge clk); rst_n = 1'b0; dcache_stall = 1'b0;
        #1 chk("rsti_we", {28'b0, dcache_we}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        quiet_cycles("rsti_quiet", 4);
        chk("rsti_nowr", emu_wr_cnt, n0);
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  sz;
        logic [31:0] a;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i * 37 + 11);
        rst_n = 1'b0; req_val = 1'b0; req_is_store = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; req_tag = '0;
        flush = 1'b0; rsp_rdy = 1'b0; dcache_stall = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_rsp_val", {31'b0, rsp_val}, 32'd0);
        chk("reset_rsp_exc", {31'b0, rsp_exc}, 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_rsp_tag", {27'b0, rsp_tag}, 32'd0);
        chk("reset_re", {31'b0, dcache_re}, 32'd0);
        chk("reset_we", {28'b0, dcache_we}, 32'd0);
        chk("reset_addr", dcache_addr, 32'd0);
        chk("reset_din", dcache_din, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("reset_req_rdy", {31'b0, req_rdy}, 32'd1);

        run_txn(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 5'd1, 0, 0, d);
        chk("sw_data_zero", d, 32'h0);
        run_txn(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 5'd2, 0, 0, d);
        chk("lb_103", d, 32'hFFFFFFDE);
        run_txn(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 5'd3, 0, 0, d);
        chk("lbu_103", d, 32'h000000DE);
        run_txn(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 5'd4, 0, 0, d);
        chk("lh_102", d, 32'hFFFFDEAD);
        run_txn(1'b0, 2'd1, 1'b1, 32'h100, 32'h0, 5'd5, 0, 0, d);
        chk("lhu_100", d, 32'h0000BEEF);
        run_txn(1'b1, 2'd0, 1'b0, 32'h101, 32'h00000012, 5'd6, 0, 0, d);
        run_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5'd7, 0, 0, d);
        chk("lw_merge", d, 32'hDEAD12EF);
        run_txn(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 5'd8, 0, 0, d);
        run_txn(1'b1, 2'd1, 1'b0, 32'h101, 32'h1234, 5'd9, 0, 0, d);
        run_txn(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 5'd10, 0, 0, d);
        run_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5'd11, 3, 0, d);
        run_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5'd12, 0, 2, d);

        flush_in_issue(32'h104, 32'hCAFEF00D);
        run_txn(1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 5'd13, 0, 0, d);
        flush_in_wait(32'h108);
        flush_in_resp(32'h10C, 32'h13572468);
        run_txn(1'b0, 2'd2, 1'b0, 32'h10C, 32'h0, 5'd14, 0, 0, d);
        flush_with_req();
        reset_in_wait(32'h110);
        reset_in_issue(32'h114);
        run_txn(1'b0, 2'd2, 1'b0, 32'h114, 32'h0, 5'd15, 0, 0, d);

        for (int t = 0; t < 60; t++) begin
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = 32'h100 + $urandom_range(0, 63);
            if (sz != 2'd3 && $urandom_range(0, 1) == 1) a = a & ~((32'd1 << sz) - 32'd1);
            run_txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                    5'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
